// File: rtl/fnd_pkg.sv
// Shared types and helpers for the BCD stopwatch: FSM states and the
// active-low 7-segment decode.
package fnd_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g..a}; dp is always off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit of the stopwatch counter. carry/borrow tell the next
// digit up to step on the same tick.
module bcd_digit_cell (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       down,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic [3:0] digit,
    output logic       carry,
    output logic       borrow
);

    assign carry  = en && !down && (digit == 4'd9);
    assign borrow = en &&  down && (digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digit <= 4'd0;
        else if (clr)
            digit <= 4'd0;
        else if (load)
            digit <= (ld_val > 4'd9) ? 4'd9 : ld_val;
        else if (en) begin
            if (down)
                digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            else
                digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_fnd.sv
// Up/down decimal stopwatch with run/stop control, load/clear, wrap flag
// and a multiplexed active-low 7-segment display driver.
module bcd_stopwatch_fnd
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_run_tog,
    input  logic                    i_mode_tog,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_load_bcd,
    output logic [4*NUM_DIGITS-1:0] o_count_bcd,
    output logic                    o_running,
    output logic                    o_down,
    output logic                    o_wrap,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic [7:0]              fnd_data
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    state_t state, state_nxt;
    logic [TW-1:0] psc;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;

    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0]      en, cy, bw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= STOP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_run_tog) state_nxt = (state == RUN) ? STOP : RUN;
    end

    always_comb begin
        o_running = (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             o_down <= 1'b0;
        else if (i_mode_tog) o_down <= ~o_down;
    end

    // Prescaler holds in STOP so a resume keeps the tick phase.
    assign tick = o_running && (psc == TICK_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  psc <= '0;
        else if (i_clear || i_load) psc <= '0;
        else if (o_running)       psc <= (psc == TICK_MAX) ? '0 : psc + 1'b1;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_first
            assign en[i] = tick;
        end else begin : g_chain
            assign en[i] = cy[i-1] | bw[i-1];
        end
        bcd_digit_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .down   (o_down),
            .clr    (i_clear),
            .load   (i_load),
            .ld_val (i_load_bcd[4*i +: 4]),
            .digit  (digits[i]),
            .carry  (cy[i]),
            .borrow (bw[i])
        );
    end

    assign o_count_bcd = digits;

    // Ripple out of the top digit is exactly the all-9s/all-0s rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_wrap <= 1'b0;
        else     o_wrap <= (cy[NUM_DIGITS-1] | bw[NUM_DIGITS-1]) & ~i_clear & ~i_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic blank;
    always_comb begin
        blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(scan_idx) && digits[i] != 4'd0) blank = 1'b0;
        if (scan_idx == '0 || BLANK_LZ == 0) blank = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= ~NUM_DIGITS'(1);
            fnd_data <= seg7(4'd0);
        end else begin
            fnd_com  <= ~(NUM_DIGITS'(1) << scan_idx);
            fnd_data <= blank ? SEG_BLANK : seg7(digits[scan_idx]);
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_fnd.sv
// Randomized bench for bcd_stopwatch_fnd against an integer-valued
// reference model of the stopwatch and its display scan.
module tb_bcd_stopwatch_fnd;

    localparam int ND  = 4;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int MOD = 10000;

    logic        clk = 0, rst = 0;
    logic        run_tog = 0, mode_tog = 0, clear = 0, load = 0;
    logic [15:0] load_bcd = '0;
    logic [15:0] count_bcd;
    logic        running, down, wrap;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    always #5 clk = ~clk;

    bcd_stopwatch_fnd #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst),
        .i_run_tog(run_tog), .i_mode_tog(mode_tog), .i_clear(clear), .i_load(load),
        .i_load_bcd(load_bcd),
        .o_count_bcd(count_bcd), .o_running(running), .o_down(down), .o_wrap(wrap),
        .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int         m_cnt, m_psc, m_ncyc;
    bit         m_run, m_down, m_wrap;
    logic [3:0] m_com;
    logic [7:0] m_data;

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_of(input int v, input int k);
        if (k > 0 && v < pow10(k)) return 8'hFF;
        return SEG[(v / pow10(k)) % 10];
    endfunction

    function automatic int dec_sat(input logic [15:0] b);
        int v = 0;
        for (int k = 0; k < ND; k++) begin
            int n = int'(b[4*k +: 4]);
            v += ((n > 9) ? 9 : n) * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b = '0;
        for (int k = 0; k < ND; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return b;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_psc = 0; m_ncyc = 0;
        m_run = 0; m_down = 0; m_wrap = 0;
        m_com = 4'b1110; m_data = 8'hC0;
    endtask

    task automatic model_step(input bit r, input bit m, input bit c, input bit l, input logic [15:0] lv);
        int  idx;
        bit  tk;
        idx    = (m_ncyc / SD) % ND;
        m_com  = ~(4'(1) << idx);
        m_data = seg_of(m_cnt, idx);
        m_ncyc++;
        tk     = m_run && (m_psc == TD - 1);
        m_wrap = 0;
        if (c) begin
            m_cnt = 0; m_psc = 0;
        end else if (l) begin
            m_cnt = dec_sat(lv); m_psc = 0;
        end else begin
            if (m_run) m_psc = (m_psc + 1) % TD;
            if (tk) begin
                if (m_down) begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MOD - 1) % MOD;
                end else begin
                    m_wrap = (m_cnt == MOD - 1);
                    m_cnt  = (m_cnt + 1) % MOD;
                end
            end
        end
        m_run  ^= r;
        m_down ^= m;
    endtask

    task automatic check_all(input string ph);
        check({ph, ".count"},   32'(count_bcd), 32'(to_bcd(m_cnt)));
        check({ph, ".running"}, 32'(running),   32'(m_run));
        check({ph, ".down"},    32'(down),      32'(m_down));
        check({ph, ".wrap"},    32'(wrap),      32'(m_wrap));
        check({ph, ".com"},     32'(fnd_com),   32'(m_com));
        check({ph, ".data"},    32'(fnd_data),  32'(m_data));
    endtask

    task automatic clear_inputs();
        run_tog = 0; mode_tog = 0; clear = 0; load = 0;
    endtask

    initial begin
        model_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0 && $urandom_range(0, 699) == 0) begin
                clear_inputs();
                rst = 1;
                #1;
                model_reset();
                check_all("rst_async");
                @(posedge clk);
                @(negedge clk);
                check_all("rst_hold");
                rst = 0;
            end
            run_tog  = ($urandom_range(0, 39) == 0);
            mode_tog = ($urandom_range(0, 29) == 0);
            clear    = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 4))
                0:       load_bcd = 16'($urandom());
                1:       load_bcd = 16'h9998;
                2:       load_bcd = 16'h0001;
                3:       load_bcd = 16'h0040 + 16'($urandom_range(0, 9));
                default: load_bcd = 16'h0555;
            endcase
            @(posedge clk);
            model_step(run_tog, mode_tog, clear, load, load_bcd);
            @(negedge clk);
            check_all("run");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
